// File: rtl/baud_tx_pkg.sv
// Shared types and helpers for the baud-strobed serial transmitter family.
// Frame length is counted in baud periods: start + data + optional parity + stop.
package baud_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic TX_IDLE_LEVEL = 1'b1;

   function automatic int frame_len(input int data_w, input int parity_en, input int stop_bits);
      return 1 + data_w + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/baud_tick_det.sv
// Rising-edge detector on the divider output, producing a one-cycle baud tick.
// Kept separate so the receive side can share the same strobe logic.
module baud_tick_det (
   input  logic clk_in,
   input  logic rst,
   input  logic baud_clk,
   output logic tick
);

   logic baud_q;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         baud_q <= 1'b0;
      end else begin
         baud_q <= baud_clk;
      end
   end

   assign tick = baud_clk & ~baud_q;

endmodule

// File: rtl/baud_serial_tx.sv
// UART-style byte-serial transmitter: valid/ready word input, LSB-first frame on tx,
// every line transition aligned to a tick derived from the divider's square wave.
module baud_serial_tx
   import baud_tx_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              baud_clk,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

   tx_state_t         state_q;
   tx_state_t         state_d;
   logic              tick;
   logic              accept;
   logic              last_bit;
   logic              last_stop;
   logic [DATA_W-1:0] sr;
   logic              parity_q;
   logic [CNT_W-1:0]  bit_cnt;
   logic [1:0]        stop_cnt;

   baud_tick_det u_tick (
      .clk_in   (clk_in),
      .rst      (rst),
      .baud_clk (baud_clk),
      .tick     (tick)
   );

   assign last_bit  = (bit_cnt == LAST_BIT);
   assign last_stop = (stop_cnt == LAST_STOP);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = ARMED;
         ARMED:   if (tick) state_d = START;
         START:   if (tick) state_d = DATA;
         DATA:    if (tick && last_bit) state_d = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY:  if (tick) state_d = STOP;
         STOP:    if (tick && last_stop) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE) & rst;
      busy     = (state_q != IDLE);
      accept   = in_valid & in_ready;
   end

   // Line driver: tx only moves on tick cycles, so each bit lasts exactly one baud period.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         sr         <= '0;
         parity_q   <= 1'b0;
         bit_cnt    <= '0;
         stop_cnt   <= '0;
         tx         <= TX_IDLE_LEVEL;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (accept) begin
            sr       <= in_data;
            parity_q <= (PARITY_ODD != 0) ? ~^in_data : ^in_data;
         end else if (tick) begin
            unique case (state_q)
               ARMED: tx <= 1'b0;
               START: begin
                  tx      <= sr[0];
                  sr      <= sr >> 1;
                  bit_cnt <= '0;
               end
               DATA: begin
                  if (last_bit) begin
                     if (PARITY_EN != 0) begin
                        tx <= parity_q;
                     end else begin
                        tx       <= TX_IDLE_LEVEL;
                        stop_cnt <= '0;
                     end
                  end else begin
                     tx      <= sr[0];
                     sr      <= sr >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               PARITY: begin
                  tx       <= TX_IDLE_LEVEL;
                  stop_cnt <= '0;
               end
               STOP: begin
                  if (last_stop) begin
                     frame_done <= 1'b1;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
